linkspeed_tx_multi: RTL and testbench

//  Parametrised TX-side MBTRAIN.LINKSPEED sequencer for N lanes split into G equal lane groups.
//  - Handshake sequence: start req/resp, point-test launch, per-group result analysis,

---
 rtl/mbtrain_pkg.sv | 28 ++
 rtl/lane_group_reduce.sv | 16 +
 rtl/linkspeed_tx_multi.sv | 271 +++++++++++++++++++++++++++
 tb/tb_linkspeed_tx_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN definitions: 4-bit sideband message codes, LINKSPEED state
// encoding and the per-group error-encoding constants.
package mbtrain_pkg;

   localparam logic [3:0] MSG_NONE            = 4'b0000;
   localparam logic [3:0] MSG_START_REQ       = 4'b0001;
   localparam logic [3:0] MSG_START_RESP      = 4'b0010;
   localparam logic [3:0] MSG_ERROR_REQ       = 4'b0011;
   localparam logic [3:0] MSG_ERROR_RESP      = 4'b0100;
   localparam logic [3:0] MSG_REPAIR_REQ      = 4'b0101;
   localparam logic [3:0] MSG_REPAIR_RESP     = 4'b0110;
   localparam logic [3:0] MSG_DEGRADE_REQ     = 4'b0111;
   localparam logic [3:0] MSG_DEGRADE_RESP    = 4'b1000;
   localparam logic [3:0] MSG_DONE_REQ        = 4'b1001;
   localparam logic [3:0] MSG_DONE_RESP       = 4'b1010;
   localparam logic [3:0] MSG_PHYRETRAIN_REQ  = 4'b1011;
   localparam logic [3:0] MSG_PHYRETRAIN_RESP = 4'b1100;

   localparam logic [1:0] ENC_ALL_OK  = 2'b01;
   localparam logic [1:0] ENC_SOME_OK = 2'b10;
   localparam logic [1:0] ENC_NONE_OK = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE, ST_START_REQ, ST_POINT_TEST, ST_ANALYSE, ST_PHYRETRAIN_REQ,
      ST_DONE_REQ, ST_ERROR_REQ, ST_REPAIR_REQ, ST_DEGRADE_REQ, ST_FINISHED
   } ls_state_e;

endpackage

// File: rtl/lane_group_reduce.sv
// Combinational per-group AND of lane pass bits: a group is functional only
// when every lane in it passed.
module lane_group_reduce #(
   parameter int NUM_LANES = 16,
   parameter int GROUP_W   = 8,
   localparam int NUM_GROUPS = NUM_LANES / GROUP_W
) (
   input  logic [NUM_LANES-1:0]  lanes_i,
   output logic [NUM_GROUPS-1:0] group_ok_o
);

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      assign group_ok_o[g] = &lanes_i[g*GROUP_W +: GROUP_W];
   end

endmodule

// File: rtl/linkspeed_tx_multi.sv
// TX-side MBTRAIN.LINKSPEED sequencer for NUM_LANES lanes in GROUP_W-lane groups.
// Optional request-state timeout is built when LINKSPEED_TIMEOUT_EN is defined.
module linkspeed_tx_multi
   import mbtrain_pkg::*;
#(
   parameter int NUM_LANES   = 16,
   parameter int GROUP_W     = 8,
   parameter int TIMEOUT_CYC = 8000,
   localparam int NUM_GROUPS = NUM_LANES / GROUP_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic [1:0]            i_test_mode,
   input  logic [3:0]            i_sideband_message,
   input  logic                  i_rx_valid,
   input  logic                  i_busy_negedge_detected,
   input  logic                  i_point_test_ack,
   input  logic                  i_valid_framing_error,
   input  logic [NUM_LANES-1:0]  i_lanes_result,
   input  logic                  i_from_repair,
   input  logic [NUM_GROUPS-1:0] i_prev_group_ok,
   output logic [3:0]            o_sideband_message,
   output logic                  o_valid_tx,
   output logic                  o_point_test_en,
   output logic [1:0]            o_test_mode,
   output logic [NUM_GROUPS-1:0] o_group_ok,
   output logic [1:0]            o_phyretrain_error_enc,
   output logic                  o_phyretrain_flag,
   output logic                  o_error_flag,
   output logic                  o_repair_flag,
   output logic                  o_degrade_flag,
   output logic                  o_timeout_disable,
   output logic                  o_timeout,
   output logic                  o_test_ack
);

   ls_state_e             state_q, state_d;
   logic [3:0]            msg_q, msg_d;
   logic                  valid_q, valid_d, vset, vclr;
   logic                  pt_q, pt_d, ack_q, ack_d, tdis_q, tdis_d, fe_q, fe_d;
   logic [1:0]            mode_q, mode_d, enc_q, enc_d;
   logic [NUM_GROUPS-1:0] gok_q, gok_d, gok_w;
   logic                  phy_f_q, err_f_q, rep_f_q, deg_f_q;
   logic                  phy_f_d, err_f_d, rep_f_d, deg_f_d;

   lane_group_reduce #(.NUM_LANES(NUM_LANES), .GROUP_W(GROUP_W)) u_reduce (
      .lanes_i    (i_lanes_result),
      .group_ok_o (gok_w)
   );

   function automatic logic rx_is(input logic v, input logic [3:0] m, input logic [3:0] c);
      return v && (m == c);
   endfunction

`ifdef LINKSPEED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d, timed;
   assign timed = state_q inside {ST_START_REQ, ST_PHYRETRAIN_REQ, ST_DONE_REQ,
                                  ST_ERROR_REQ, ST_REPAIR_REQ, ST_DEGRADE_REQ};
`endif

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      vset    = 1'b0;
      vclr    = i_busy_negedge_detected & ~i_rx_valid;
      pt_d    = pt_q;
      tdis_d  = tdis_q;
      mode_d  = mode_q;
      gok_d   = gok_q;
      enc_d   = enc_q;
      fe_d    = fe_q;
      unique case (state_q)
         ST_IDLE: begin
            tdis_d = 1'b0;
            if (i_en) begin
               state_d = ST_START_REQ;
               msg_d   = MSG_START_REQ;
               vset    = 1'b1;
               mode_d  = i_test_mode;
               fe_d    = 1'b0;
            end
         end
         ST_START_REQ:
            if (rx_is(i_rx_valid, i_sideband_message, MSG_START_RESP)) begin
               state_d = ST_POINT_TEST;
               pt_d    = 1'b1;
            end
         ST_POINT_TEST: begin
            fe_d = fe_q | i_valid_framing_error;
            if (i_point_test_ack) begin
               state_d = ST_ANALYSE;
               pt_d    = 1'b0;
               gok_d   = gok_w;
               enc_d   = (&gok_w) ? ENC_ALL_OK : (|gok_w) ? ENC_SOME_OK : ENC_NONE_OK;
            end
         end
         ST_ANALYSE:
            if (fe_q) begin
               state_d = ST_PHYRETRAIN_REQ;
               msg_d   = MSG_PHYRETRAIN_REQ;
               vset    = 1'b1;
            end else if ((i_from_repair && |(i_prev_group_ok & gok_q)) || &gok_q) begin
               // a pre-set exit flag suppresses the DONE code; DONE_REQ then falls through
               state_d = ST_DONE_REQ;
               vset    = ~(phy_f_q | err_f_q | rep_f_q | deg_f_q);
               msg_d   = vset ? MSG_DONE_REQ : MSG_NONE;
            end else begin
               state_d = ST_ERROR_REQ;
               vset    = ~phy_f_q;
               msg_d   = vset ? MSG_ERROR_REQ : MSG_NONE;
            end
         ST_PHYRETRAIN_REQ:
            if (rx_is(i_rx_valid, i_sideband_message, MSG_PHYRETRAIN_RESP)) begin
               state_d = ST_FINISHED;
               tdis_d  = 1'b1;
            end
         ST_DONE_REQ:
            if (phy_f_q | err_f_q | rep_f_q | deg_f_q) begin
               state_d = ST_FINISHED;
               msg_d   = MSG_NONE;
               vclr    = 1'b1;
               tdis_d  = 1'b1;
            end else if (rx_is(i_rx_valid, i_sideband_message, MSG_DONE_RESP)) begin
               state_d = ST_FINISHED;
               tdis_d  = 1'b1;
            end
         ST_ERROR_REQ:
            if (phy_f_q) begin
               state_d = ST_FINISHED;
               msg_d   = MSG_NONE;
               vclr    = 1'b1;
               tdis_d  = 1'b1;
            end else if (rx_is(i_rx_valid, i_sideband_message, MSG_ERROR_RESP)) begin
               state_d = (|gok_q) ? ST_REPAIR_REQ : ST_DEGRADE_REQ;
               msg_d   = (|gok_q) ? MSG_REPAIR_REQ : MSG_DEGRADE_REQ;
               vset    = 1'b1;
            end
         ST_REPAIR_REQ:
            if (phy_f_q | deg_f_q) begin
               state_d = ST_FINISHED;
               msg_d   = MSG_NONE;
               vclr    = 1'b1;
               tdis_d  = 1'b1;
            end else if (rx_is(i_rx_valid, i_sideband_message, MSG_REPAIR_RESP)) begin
               state_d = ST_FINISHED;
               tdis_d  = 1'b1;
            end
         ST_DEGRADE_REQ:
            if (phy_f_q) begin
               state_d = ST_FINISHED;
               msg_d   = MSG_NONE;
               vclr    = 1'b1;
               tdis_d  = 1'b1;
            end else if (rx_is(i_rx_valid, i_sideband_message, MSG_DEGRADE_RESP)) begin
               state_d = ST_FINISHED;
               tdis_d  = 1'b1;
            end
         ST_FINISHED: ;
         default: state_d = ST_IDLE;
      endcase
`ifdef LINKSPEED_TIMEOUT_EN
      tmo_d = 1'b0;
      if (timed && !tdis_q && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
         tmo_d   = 1'b1;
         state_d = ST_FINISHED;
         msg_d   = MSG_NONE;
         vset    = 1'b0;
         vclr    = 1'b1;
      end
`endif
      if (!i_en && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         msg_d   = MSG_NONE;
         vset    = 1'b0;
         vclr    = 1'b1;
         pt_d    = 1'b0;
`ifdef LINKSPEED_TIMEOUT_EN
         tmo_d   = 1'b0;
`endif
      end
      valid_d = vclr ? 1'b0 : (vset | valid_q);
      ack_d   = (state_d == ST_FINISHED);
`ifdef LINKSPEED_TIMEOUT_EN
      cnt_d = (state_d != state_q) ? '0 : (timed && !tdis_q) ? cnt_q + 1'b1 : cnt_q;
`endif
   end

   // flags see both our own transmitted request and the remote's request
   always_comb begin
      phy_f_d = phy_f_q | rx_is(i_rx_valid, i_sideband_message, MSG_PHYRETRAIN_REQ)
                        | rx_is(valid_q, msg_q, MSG_PHYRETRAIN_REQ);
      err_f_d = err_f_q | rx_is(i_rx_valid, i_sideband_message, MSG_ERROR_REQ)
                        | rx_is(valid_q, msg_q, MSG_ERROR_REQ);
      rep_f_d = rep_f_q | rx_is(i_rx_valid, i_sideband_message, MSG_REPAIR_REQ)
                        | rx_is(valid_q, msg_q, MSG_REPAIR_REQ);
      deg_f_d = deg_f_q | rx_is(i_rx_valid, i_sideband_message, MSG_DEGRADE_REQ)
                        | rx_is(valid_q, msg_q, MSG_DEGRADE_REQ);
      if (state_q == ST_IDLE) begin
         phy_f_d = 1'b0;
         err_f_d = 1'b0;
         rep_f_d = 1'b0;
         deg_f_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         msg_q   <= MSG_NONE;
         valid_q <= 1'b0;
         pt_q    <= 1'b0;
         ack_q   <= 1'b0;
         tdis_q  <= 1'b0;
         fe_q    <= 1'b0;
         mode_q  <= '0;
         gok_q   <= '0;
         enc_q   <= '0;
         phy_f_q <= 1'b0;
         err_f_q <= 1'b0;
         rep_f_q <= 1'b0;
         deg_f_q <= 1'b0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         valid_q <= valid_d;
         pt_q    <= pt_d;
         ack_q   <= ack_d;
         tdis_q  <= tdis_d;
         fe_q    <= fe_d;
         mode_q  <= mode_d;
         gok_q   <= gok_d;
         enc_q   <= enc_d;
         phy_f_q <= phy_f_d;
         err_f_q <= err_f_d;
         rep_f_q <= rep_f_d;
         deg_f_q <= deg_f_d;
      end
   end

`ifdef LINKSPEED_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end
   assign o_timeout = tmo_q;
`else
   assign o_timeout = 1'b0;
`endif

   assign o_sideband_message     = msg_q;
   assign o_valid_tx             = valid_q;
   assign o_point_test_en        = pt_q;
   assign o_test_mode            = mode_q;
   assign o_group_ok             = gok_q;
   assign o_phyretrain_error_enc = enc_q;
   assign o_phyretrain_flag      = phy_f_q;
   assign o_error_flag           = err_f_q;
   assign o_repair_flag          = rep_f_q;
   assign o_degrade_flag         = deg_f_q;
   assign o_timeout_disable      = tdis_q;
   assign o_test_ack             = ack_q;

endmodule

// File: tb/tb_linkspeed_tx_multi.sv
// Directed bench for linkspeed_tx_multi: expected TX codes go into a scoreboard
// queue as stimulus is driven and are compared against codes the DUT emits.
module tb_linkspeed_tx_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_en, i_rx_valid, i_busy, i_pt_ack, i_fe, i_from_repair;
   logic [1:0]  i_test_mode, i_prev_ok;
   logic [3:0]  i_msg;
   logic [15:0] i_lanes;
   logic [3:0]  o_msg;
   logic        o_valid_tx, o_pt_en, o_phy_f, o_err_f, o_rep_f, o_deg_f;
   logic        o_tdis, o_timeout, o_test_ack;
   logic [1:0]  o_test_mode, o_group_ok, o_enc;

   int         errs = 0;
   int         checks = 0;
   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];
   logic       pv = 1'b0;
   logic [3:0] pm = 4'h0;

   linkspeed_tx_multi #(.NUM_LANES(16), .GROUP_W(8), .TIMEOUT_CYC(20)) dut (
      .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_test_mode(i_test_mode),
      .i_sideband_message(i_msg), .i_rx_valid(i_rx_valid),
      .i_busy_negedge_detected(i_busy), .i_point_test_ack(i_pt_ack),
      .i_valid_framing_error(i_fe), .i_lanes_result(i_lanes),
      .i_from_repair(i_from_repair), .i_prev_group_ok(i_prev_ok),
      .o_sideband_message(o_msg), .o_valid_tx(o_valid_tx), .o_point_test_en(o_pt_en),
      .o_test_mode(o_test_mode), .o_group_ok(o_group_ok), .o_phyretrain_error_enc(o_enc),
      .o_phyretrain_flag(o_phy_f), .o_error_flag(o_err_f), .o_repair_flag(o_rep_f),
      .o_degrade_flag(o_deg_f), .o_timeout_disable(o_tdis), .o_timeout(o_timeout),
      .o_test_ack(o_test_ack)
   );

   always #5 clk = ~clk;

   // record each new TX message (valid rising or code change while valid)
   always @(negedge clk) begin
      if (o_valid_tx && (!pv || o_msg != pm)) obs_q.push_back(o_msg);
      pv <= o_valid_tx;
      pm <= o_msg;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic rx(input logic [3:0] code);
      i_rx_valid = 1'b1;
      i_msg      = code;
      cyc(1);
      i_rx_valid = 1'b0;
      i_msg      = 4'h0;
   endtask

   task automatic drain(input string tag);
      logic [7:0] o;
      logic [3:0] e;
      cyc(1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? {4'h0, obs_q.pop_front()} : 8'hFF;
         chk({tag, "_msg"}, 32'(o), 32'(e));
      end
      chk({tag, "_extra_msgs"}, 32'(obs_q.size()), 32'd0);
      obs_q.delete();
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      while (!o_test_ack && n < 50) begin
         cyc(1);
         n++;
      end
      chk({tag, "_ack"}, 32'(o_test_ack), 32'd1);
   endtask

   // IDLE -> START_REQ -> START_RESP -> POINT_TEST
   task automatic start_step();
      i_en = 1'b1;
      exp_q.push_back(4'b0001);
      cyc(2);
      rx(4'b0010);
   endtask

   task automatic run_pt(input logic [15:0] lanes, input logic fe);
      i_lanes  = lanes;
      i_fe     = fe;
      i_pt_ack = 1'b1;
      cyc(1);
      i_pt_ack = 1'b0;
      i_fe     = 1'b0;
      cyc(1);
   endtask

   task automatic stop_step();
      i_en = 1'b0;
      cyc(2);
   endtask

   initial begin
      rst_n = 1'b0; i_en = 1'b0; i_rx_valid = 1'b0; i_busy = 1'b0; i_pt_ack = 1'b0;
      i_fe = 1'b0; i_from_repair = 1'b0; i_test_mode = 2'b10; i_prev_ok = 2'b00;
      i_msg = 4'h0; i_lanes = 16'h0;
      cyc(3);
      chk("rst_msg", 32'(o_msg), 32'd0);
      chk("rst_valid", 32'(o_valid_tx), 32'd0);
      chk("rst_ack", 32'(o_test_ack), 32'd0);
      chk("rst_enc", 32'(o_enc), 32'd0);
      chk("rst_timeout", 32'(o_timeout), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // 1: all lanes pass -> DONE
      start_step();
      chk("t1_mode", 32'(o_test_mode), 32'b10);
      chk("t1_pt_en", 32'(o_pt_en), 32'd1);
      exp_q.push_back(4'b1001);
      run_pt(16'hFFFF, 1'b0);
      chk("t1_pt_off", 32'(o_pt_en), 32'd0);
      chk("t1_gok", 32'(o_group_ok), 32'b11);
      chk("t1_enc", 32'(o_enc), 32'b01);
      cyc(3);
      rx(4'b1010);
      wait_ack("t1");
      chk("t1_tdis", 32'(o_tdis), 32'd1);
      chk("t1_flags", 32'({o_phy_f, o_err_f, o_rep_f, o_deg_f}), 32'd0);
      i_busy = 1'b1;
      cyc(1);
      i_busy = 1'b0;
      chk("t1_valid_clr", 32'(o_valid_tx), 32'd0);
      drain("t1");
      stop_step();
      chk("t1_ack_off", 32'(o_test_ack), 32'd0);

      // 2: upper group fails -> ERROR -> REPAIR
      start_step();
      exp_q.push_back(4'b0011);
      run_pt(16'h00FF, 1'b0);
      chk("t2_enc", 32'(o_enc), 32'b10);
      chk("t2_gok", 32'(o_group_ok), 32'b01);
      exp_q.push_back(4'b0101);
      rx(4'b0100);
      cyc(2);
      chk("t2_rep_flag", 32'(o_rep_f), 32'd1);
      chk("t2_err_flag", 32'(o_err_f), 32'd1);
      rx(4'b0110);
      wait_ack("t2");
      drain("t2");
      stop_step();

      // 3: all lanes fail -> ERROR -> DEGRADE
      start_step();
      exp_q.push_back(4'b0011);
      run_pt(16'h0000, 1'b0);
      chk("t3_enc", 32'(o_enc), 32'b11);
      exp_q.push_back(4'b0111);
      rx(4'b0100);
      cyc(2);
      rx(4'b1000);
      wait_ack("t3");
      chk("t3_deg_flag", 32'(o_deg_f), 32'd1);
      drain("t3");
      stop_step();

      // 4: framing error -> PHYRETRAIN, remote repair req received meanwhile
      start_step();
      exp_q.push_back(4'b1011);
      run_pt(16'hFFFF, 1'b1);
      cyc(1);
      rx(4'b0101);
      cyc(1);
      chk("t4_not_done", 32'(o_test_ack), 32'd0);
      rx(4'b1100);
      wait_ack("t4");
      chk("t4_phy_flag", 32'(o_phy_f), 32'd1);
      chk("t4_rep_flag", 32'(o_rep_f), 32'd1);
      drain("t4");
      stop_step();

      // 5: after repair, surviving group still ok -> DONE, no ERROR_REQ
      i_from_repair = 1'b1;
      i_prev_ok     = 2'b10;
      start_step();
      exp_q.push_back(4'b1001);
      run_pt(16'hFF00, 1'b0);
      chk("t5_enc", 32'(o_enc), 32'b10);
      rx(4'b1010);
      wait_ack("t5");
      chk("t5_err_flag", 32'(o_err_f), 32'd0);
      drain("t5");
      stop_step();
      i_from_repair = 1'b0;
      i_prev_ok     = 2'b00;

      // abort mid point test: outputs cleared, analysis results held
      start_step();
      i_en = 1'b0;
      cyc(1);
      chk("ab_pt_en", 32'(o_pt_en), 32'd0);
      chk("ab_valid", 32'(o_valid_tx), 32'd0);
      chk("ab_msg", 32'(o_msg), 32'd0);
      chk("ab_gok_held", 32'(o_group_ok), 32'b10);
      chk("ab_enc_held", 32'(o_enc), 32'b10);
      drain("ab");
      cyc(1);

`ifdef LINKSPEED_TIMEOUT_EN
      // 6: no START_RESP -> timeout after TIMEOUT_CYC cycles
      begin
         int n = 0;
         i_en = 1'b1;
         exp_q.push_back(4'b0001);
         cyc(1);
         while (!o_timeout && n < 40) begin
            cyc(1);
            n++;
         end
         chk("t6_tmo", 32'(o_timeout), 32'd1);
         chk("t6_cycle", 32'(n), 32'd20);
         chk("t6_valid", 32'(o_valid_tx), 32'd0);
         cyc(1);
         chk("t6_tmo_pulse", 32'(o_timeout), 32'd0);
         chk("t6_ack", 32'(o_test_ack), 32'd1);
         drain("t6");
         stop_step();
      end
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
